arb_resp_router: RTL and testbench
==================================

# arb_resp_router

Return-path companion to the round-robin request arbiter. It records the one-hot grant of every request the arbiter forwards downstream, then steers the in-order response stream back to the requester that issued it. It sits between the shared downstream target, which returns responses strictly in issue order, and the WIDTH requester ports. It is the responder-side mirror of the grant path.

## Interface
- WIDTH, 16: number of requester ports; same value as the arbiter instance.
- DATA_W, 32: response payload width.
- DEPTH, 8: maximum outstanding requests; power of two, at least 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- grant  in  WIDTH  one-hot grant from the arbiter, sampled only on issue handshake.
- issue_valid  in  1  downstream accepts the granted request this cycle.
- issue_ready  out  1  order FIFO can record an issue.
- resp_valid  in  1  downstream response present.
- resp_data  in  DATA_W  response payload.
- resp_ready  out  1  response consumed this cycle.
- out_valid  out  WIDTH  per-port response valid; at most one bit set.
- out_data  out  DATA_W  shared payload bus, meaningful where out_valid is set.
- out_ready  in  WIDTH  per-port accept.
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_grant  out  1  sticky: non-one-hot grant seen on an issue handshake.
- err_orphan  out  1  sticky: response arrived with no outstanding issue.

## Operation
- Order FIFO: DEPTH entries of $clog2(WIDTH)-bit port index, with wr_ptr, rd_ptr and count registers. Pointers wrap modulo DEPTH.
- issue_ready = (count != DEPTH). It is not a function of a same-cycle pop; a full FIFO stalls even if a pop occurs that cycle.
- Push: on issue_valid & issue_ready with grant one-hot, encode grant to an index, write it at wr_ptr and increment wr_ptr.
- Bad grant: on issue_valid & issue_ready with grant zero or multi-hot, nothing is pushed and err_grant is set.
- Routing is combinational from the FIFO head. When count != 0: out_valid = resp_valid ? (1 << head_idx) : 0, out_data = resp_data, resp_ready = out_ready[head_idx].
- Pop: on resp_valid & resp_ready with count != 0, increment rd_ptr.
- Orphan: resp_valid with count == 0 drives resp_ready = 1, drops the beat, sets err_orphan, and drives out_valid = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Reset mid-operation: all pointers, count and error flags clear and every in-flight entry is discarded. Responses after reset count as orphans.
- Reset values: issue_ready 1, resp_ready 0 unless resp_valid (orphan rule), out_valid 0, outstanding 0, err_grant 0, err_orphan 0. out_data follows resp_data.

## Timing
- A push is visible at the head one cycle after the issue handshake. No same-cycle bypass: a response arriving in the push cycle with count == 0 is an orphan.
- Response path latency is 0 cycles, resp_valid to out_valid.
- A stalled port (out_ready low) holds resp_ready low. resp_data must then stay stable, following normal valid/ready rules.
- outstanding updates one cycle after each handshake.
- Error flags assert the cycle after the offending event and clear only on rst.

## Structure
- Shared package arb_pkg: localparams IDX_W = $clog2(WIDTH) and CNT_W = $clog2(DEPTH)+1, plus typedefs port_idx_t and cnt_t. The arbiter instance uses the same package.
- Sub-module onehot_enc (WIDTH in, IDX_W out, plus a valid_onehot flag): a combinational encoder that also detects zero and multi-hot input.
- FIFO storage is inline register arrays; no separate FIFO module.

## Test plan
- Three issues with grant 0x0004, 0x0100, 0x0001, then three responses 0xA, 0xB, 0xC with all out_ready = 1 -> out_valid 0x0004, 0x0100, 0x0001 on successive beats with data A, B, C; outstanding 3 -> 0.
- DEPTH = 8 issues with no responses -> issue_ready = 0 and outstanding = 8. Issue plus response in the same cycle while full -> issue not accepted, count 7. Wrap the pointers 3 times with no data mismatch.
- Head port is 5 with out_ready[5] = 0 for 4 cycles -> resp_ready = 0 and out_valid = 0x0020 held. Release -> pop, with no effect on other ports.
- grant = 0x0006 with issue_valid -> no push, outstanding unchanged, err_grant = 1 until rst.
- resp_valid with empty FIFO -> resp_ready = 1, out_valid = 0, err_orphan = 1. Issue and response in the same cycle from empty -> the response is an orphan.
- rst with 5 outstanding -> next cycle outstanding = 0, issue_ready = 1, both error flags 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared sizing for the round-robin arbiter and its response router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int IDX_W     = $clog2(DEF_WIDTH);
  localparam int CNT_W     = $clog2(DEF_DEPTH) + 1;

  typedef logic [IDX_W-1:0] port_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/arb_resp_router_onehot_enc.sv
// One-hot to binary index encoder that also flags zero or multi-hot input.
// Latency: combinational.
// Backpressure: none.
module onehot_enc #(
  parameter int WIDTH = arb_pkg::DEF_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid_onehot
);

  // OR-reduce indices of set bits; exact only when the input is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    valid_onehot = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
  end

endmodule

// File: rtl/arb_resp_router.sv
// Records granted port indices in issue order and steers in-order responses back.
// Latency: 0 cycles resp_valid->out_valid; issue visible at head 1 cycle later.
// Backpressure: resp_ready follows out_ready of the head port; full order FIFO drops issue_ready.
module arb_resp_router
  import arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       grant,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   resp_valid,
  input  logic [DATA_W-1:0]      resp_data,
  output logic                   resp_ready,
  output logic [WIDTH-1:0]       out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic [WIDTH-1:0]       out_ready,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_grant,
  output logic                   err_orphan
);

  localparam int IW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [IW-1:0] enc_idx;
  logic          enc_ok;
  logic [IW-1:0] head_idx;
  logic          empty;
  logic          issue_hs;
  logic          push;
  logic          pop;

  onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IW)
  ) u_enc (
    .onehot       (grant),
    .idx          (enc_idx),
    .valid_onehot (enc_ok)
  );

  assign empty       = (count == '0);
  assign head_idx    = mem[rd_ptr];
  assign issue_ready = (count != CW'(DEPTH));
  assign outstanding = count;
  assign issue_hs    = issue_valid & issue_ready;
  assign push        = issue_hs & enc_ok;
  assign pop         = resp_valid & resp_ready & ~empty;

  // Route the response to the head port; with nothing outstanding, sink it as an orphan.
  always_comb begin
    out_valid  = '0;
    out_data   = resp_data;
    resp_ready = resp_valid;
    if (!empty) begin
      if (resp_valid) out_valid = WIDTH'(1) << head_idx;
      resp_ready = out_ready[head_idx];
    end
  end

  // Order storage is write-only on push and needs no reset: stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_idx;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_grant  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (issue_hs && !enc_ok) err_grant  <= 1'b1;
      if (resp_valid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_resp_router.sv
module tb_arb_resp_router;

  localparam int WIDTH  = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  grant;
  logic              issue_valid;
  logic              issue_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;
  logic [WIDTH-1:0]  out_valid;
  logic [DATA_W-1:0] out_data;
  logic [WIDTH-1:0]  out_ready;
  logic [CNT_W-1:0]  outstanding;
  logic              err_grant;
  logic              err_orphan;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the queue of port numbers still owed a response.
  int q[$];
  bit m_eg;
  bit m_eo;

  always #5 clk = ~clk;

  arb_resp_router #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .grant       (grant),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .outstanding (outstanding),
    .err_grant   (err_grant),
    .err_orphan  (err_orphan)
  );

  function automatic int port_of(logic [WIDTH-1:0] g);
    for (int i = 0; i < WIDTH; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] bit_of(int p);
    logic [WIDTH-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Advance one clock; the model applies the same handshake rules to the inputs held over the edge.
  task automatic tick();
    int  sz;
    bit  do_pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_eg = 1'b0;
      m_eo = 1'b0;
    end else begin
      sz     = q.size();
      do_pop = resp_valid && (sz != 0) && out_ready[q[0]];
      if (resp_valid && sz == 0) m_eo = 1'b1;
      if (issue_valid && sz != DEPTH) begin
        if ($countones(grant) == 1) q.push_back(port_of(grant));
        else m_eg = 1'b1;
      end
      if (do_pop) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    resp_valid  = 1'b0;
    grant       = '0;
    out_ready   = '1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    resp_data = $urandom;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    n_cmp++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready got=%b exp=0", resp_ready); end
    n_cmp++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (err_grant !== 1'b0 || err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_errs got=%b%b exp=00", err_grant, err_orphan); end
    n_cmp++; if (out_data !== resp_data) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, resp_data); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0]  g [3];
    logic [DATA_W-1:0] d [3];
    g = '{16'h0004, 16'h0100, 16'h0001};
    d = '{32'hA, 32'hB, 32'hC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; grant = g[i];
      tick();
    end
    idle();
    #1;
    n_cmp++; if (outstanding !== CNT_W'(3)) begin n_fail++; $display("FAIL basic_outstanding3 got=%0d exp=3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = d[i];
      #1;
      n_cmp++; if (out_valid !== g[i]) begin n_fail++; $display("FAIL basic_out_valid%0d got=%h exp=%h", i, out_valid, g[i]); end
      n_cmp++; if (out_data !== d[i]) begin n_fail++; $display("FAIL basic_out_data%0d got=%h exp=%h", i, out_data, d[i]); end
      n_cmp++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL basic_resp_ready%0d got=%b exp=1", i, resp_ready); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL basic_outstanding0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_full_and_wrap();
    logic [WIDTH-1:0] e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue_valid = 1'b1; grant = bit_of($urandom_range(0, WIDTH-1));
      tick();
    end
    grant = bit_of($urandom_range(0, WIDTH-1));
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_issue_ready got=%b exp=0", issue_ready); end
    n_cmp++; if (outstanding !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_outstanding got=%0d exp=%0d", outstanding, DEPTH); end
    resp_valid = 1'b1; resp_data = $urandom;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_issue_ready got=%b exp=0", issue_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (outstanding !== CNT_W'(DEPTH-1)) begin n_fail++; $display("FAIL full_after_pop got=%0d exp=%0d", outstanding, DEPTH-1); end
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          issue_valid = 1'b1; grant = bit_of($urandom_range(0, WIDTH-1));
          tick();
        end
        idle();
      end
      for (int i = 0; i < 2*DEPTH && q.size() > 0; i++) begin
        resp_valid = 1'b1; resp_data = $urandom;
        #1;
        e = bit_of(q[0]);
        n_cmp++; if (out_valid !== e || out_data !== resp_data) begin n_fail++; $display("FAIL wrap_route r%0d got=%h/%h exp=%h/%h", r, out_valid, out_data, e, resp_data); end
        tick();
      end
      idle();
    end
    #1;
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL wrap_drained got=%0d exp=0", outstanding); end
  endtask

  task automatic test_stall();
    do_reset();
    issue_valid = 1'b1; grant = 16'h0020; tick();
    grant = 16'h0004; tick();
    idle();
    resp_valid = 1'b1; resp_data = 32'h5555_0005; out_ready = ~16'h0020;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL stall_resp_ready c%0d got=%b exp=0", c, resp_ready); end
      n_cmp++; if (out_valid !== 16'h0020) begin n_fail++; $display("FAIL stall_out_valid c%0d got=%h exp=0020", c, out_valid); end
      tick();
    end
    n_cmp++; if (outstanding !== CNT_W'(2)) begin n_fail++; $display("FAIL stall_outstanding got=%0d exp=2", outstanding); end
    out_ready = '1;
    #1;
    n_cmp++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", resp_ready); end
    tick();
    resp_data = 32'h5555_0002;
    #1;
    n_cmp++; if (out_valid !== 16'h0004 || outstanding !== CNT_W'(1)) begin n_fail++; $display("FAIL stall_next got=%h/%0d exp=0004/1", out_valid, outstanding); end
    tick();
    idle();
  endtask

  task automatic test_bad_grant();
    do_reset();
    issue_valid = 1'b1; grant = 16'h0200; tick();
    grant = 16'h0006; tick();
    idle();
    #1;
    n_cmp++; if (outstanding !== CNT_W'(1)) begin n_fail++; $display("FAIL bad_outstanding got=%0d exp=1", outstanding); end
    n_cmp++; if (err_grant !== 1'b1) begin n_fail++; $display("FAIL bad_err_grant got=%b exp=1", err_grant); end
    issue_valid = 1'b1; grant = '0; tick();
    idle();
    tick(); tick();
    n_cmp++; if (outstanding !== CNT_W'(1) || err_grant !== 1'b1) begin n_fail++; $display("FAIL bad_sticky got=%0d/%b exp=1/1", outstanding, err_grant); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL bad_no_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_orphan();
    do_reset();
    resp_valid = 1'b1; resp_data = $urandom;
    #1;
    n_cmp++; if (resp_ready !== 1'b1 || out_valid !== '0) begin n_fail++; $display("FAIL orphan_comb got=%b/%h exp=1/0", resp_ready, out_valid); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_early got=%b exp=0", err_orphan); end
    tick();
    idle();
    #1;
    n_cmp++; if (err_orphan !== 1'b1 || outstanding !== '0) begin n_fail++; $display("FAIL orphan_flag got=%b/%0d exp=1/0", err_orphan, outstanding); end
    do_reset();
    issue_valid = 1'b1; grant = 16'h0800; resp_valid = 1'b1;
    #1;
    n_cmp++; if (out_valid !== '0 || resp_ready !== 1'b1) begin n_fail++; $display("FAIL orphan_push_cycle got=%h/%b exp=0/1", out_valid, resp_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (outstanding !== CNT_W'(1) || err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_same_cycle got=%0d/%b exp=1/1", outstanding, err_orphan); end
    resp_valid = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 16'h0800) begin n_fail++; $display("FAIL orphan_then_route got=%h exp=0800", out_valid); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_valid = 1'b1; tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; grant = bit_of($urandom_range(0, WIDTH-1));
      tick();
    end
    grant = 16'h0003; tick();
    idle();
    n_cmp++; if (outstanding !== CNT_W'(5) || err_grant !== 1'b1 || err_orphan !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0d/%b%b exp=5/11", outstanding, err_grant, err_orphan); end
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    n_cmp++; if (outstanding !== '0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL mid_post got=%0d/%b exp=0/1", outstanding, issue_ready); end
    n_cmp++; if (err_grant !== 1'b0 || err_orphan !== 1'b0) begin n_fail++; $display("FAIL mid_errs got=%b%b exp=00", err_grant, err_orphan); end
    resp_valid = 1'b1;
    #1;
    n_cmp++; if (resp_ready !== 1'b1 || out_valid !== '0) begin n_fail++; $display("FAIL mid_orphan got=%b/%h exp=1/0", resp_ready, out_valid); end
    tick();
    idle();
  endtask

  task automatic test_random();
    int               sz;
    logic [WIDTH-1:0] e_ov;
    logic             e_rr;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      issue_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) grant = WIDTH'($urandom);
      else grant = bit_of($urandom_range(0, WIDTH-1));
      resp_valid  = ($urandom_range(0, 2) != 0);
      resp_data   = $urandom;
      out_ready   = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : '1;
      #1;
      sz   = q.size();
      e_ov = '0;
      e_rr = resp_valid;
      if (sz > 0) begin
        if (resp_valid) e_ov = bit_of(q[0]);
        e_rr = out_ready[q[0]];
      end
      n_cmp++; if (issue_ready !== (sz != DEPTH)) begin n_fail++; $display("FAIL rnd_issue_ready c%0d got=%b exp=%b", c, issue_ready, sz != DEPTH); end
      n_cmp++; if (resp_ready !== e_rr) begin n_fail++; $display("FAIL rnd_resp_ready c%0d got=%b exp=%b", c, resp_ready, e_rr); end
      n_cmp++; if (out_valid !== e_ov) begin n_fail++; $display("FAIL rnd_out_valid c%0d got=%h exp=%h", c, out_valid, e_ov); end
      n_cmp++; if (out_data !== resp_data) begin n_fail++; $display("FAIL rnd_out_data c%0d got=%h exp=%h", c, out_data, resp_data); end
      n_cmp++; if (outstanding !== CNT_W'(sz)) begin n_fail++; $display("FAIL rnd_outstanding c%0d got=%0d exp=%0d", c, outstanding, sz); end
      n_cmp++; if (err_grant !== m_eg || err_orphan !== m_eo) begin n_fail++; $display("FAIL rnd_errs c%0d got=%b%b exp=%b%b", c, err_grant, err_orphan, m_eg, m_eo); end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    resp_data = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_and_wrap();
    test_stall();
    test_bad_grant();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
